filter_dac_serializer: RTL and testbench

- Output-side consumer of `filter_top`.
- Captures each filtered sample presented on `y_n`/`valid_out`, buffers it in a small FIFO, converts it to DAC code and shifts it out MSB-first as a 16-bit SPI frame to an external DAC.
- Decouples the filter's bursty `valid_out` from the fixed-rate serial link and flags dropped samples.

---
 rtl/filter_dac_serializer.sv | 193 +++++++++++++++++++
 tb/tb_filter_dac_serializer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_dac_serializer.sv
// filter_dac_serializer: buffers filtered samples in a small FIFO and ships each one as a
// 16-bit MSB-first SPI frame to a DAC. Define DAC_LDAC_EN to add the dac_ldac_n latch strobe.
module filter_dac_serializer #(
  parameter int         DATA_W        = 10,
  parameter int         FIFO_DEPTH    = 8,
  parameter int         SCLK_DIV      = 2,
  parameter int         GAP_CYCLES    = 2,
  parameter logic [3:0] CMD_BITS      = 4'b0011,
  parameter int         OFFSET_BINARY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           y_n,
  input  logic                        valid_out,
  output logic                        dac_sclk,
  output logic                        dac_cs_n,
  output logic                        dac_mosi,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
`ifdef DAC_LDAC_EN
  output logic                        dac_ldac_n,
`endif
  output logic                        busy
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (SCLK_DIV > GAP_CYCLES) ? SCLK_DIV : GAP_CYCLES;
  localparam int DIV_W   = $clog2(CNT_MAX + 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [4:0]          bit_q;
  logic [14:0]         shreg_q;
  logic                sclk_q, cs_n_q, mosi_q, busy_q, overflow_q;
  logic [AW:0]         count_q, count_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                div_end_s, pop_s, push_s, frame_end_s, stay_active_s;
  logic [DATA_W-1:0]   code_s;
  logic [15:0]         frame_s;

  // Handshake decode, DAC code conversion and next fill level
  always_comb begin
    case (state_q)
      SETUP, SHIFT: div_end_s = (div_q == DIV_W'(SCLK_DIV - 1));
      GAP:          div_end_s = (div_q == DIV_W'(GAP_CYCLES - 1));
      default:      div_end_s = 1'b0;
    endcase
    // The end of GAP pops directly so back-to-back frames keep exactly GAP_CYCLES of cs_n high
    pop_s         = (count_q != {(AW+1){1'b0}}) &&
                    ((state_q == IDLE) || ((state_q == GAP) && div_end_s));
    push_s        = valid_out && ((count_q != FULL_LVL) || pop_s);
    frame_end_s   = (state_q == SHIFT) && div_end_s && sclk_q && (bit_q == 5'd16);
    stay_active_s = pop_s || ((state_q != IDLE) && !((state_q == GAP) && div_end_s));
    code_s = mem_q[rd_ptr_q];
    if (OFFSET_BINARY != 0) begin
      code_s[DATA_W-1] = ~mem_q[rd_ptr_q][DATA_W-1];
    end else begin
      code_s[DATA_W-1] = mem_q[rd_ptr_q][DATA_W-1];
    end
    frame_s = {CMD_BITS, code_s, 2'b00};
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_LVL;
      2'b01:   count_d = count_q - ONE_LVL;
      default: count_d = count_q;
    endcase
  end

  // Sample storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= y_n;
    end
  end

  // FIFO pointers, fill level and sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      if (valid_out && !push_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Frame sequencer: SETUP, 32 sclk half-periods, then the inter-frame gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= {DIV_W{1'b0}};
      bit_q   <= 5'd0;
      shreg_q <= 15'd0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= stay_active_s || (count_d != {(AW+1){1'b0}});
      if (pop_s) begin
        state_q <= SETUP;
        div_q   <= {DIV_W{1'b0}};
        bit_q   <= 5'd0;
        shreg_q <= frame_s[14:0];
        sclk_q  <= 1'b0;
        cs_n_q  <= 1'b0;
        mosi_q  <= frame_s[15];
      end else begin
        case (state_q)
          IDLE: begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
          end
          SETUP: begin
            if (div_end_s) begin
              state_q <= SHIFT;
              div_q   <= {DIV_W{1'b0}};
              bit_q   <= 5'd0;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          SHIFT: begin
            if (!div_end_s) begin
              div_q <= div_q + DIV_W'(1);
            end else begin
              div_q <= {DIV_W{1'b0}};
              if (!sclk_q) begin
                sclk_q <= 1'b1;
                bit_q  <= bit_q + 5'd1;
              end else if (frame_end_s) begin
                state_q <= GAP;
                sclk_q  <= 1'b0;
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
              end else begin
                sclk_q  <= 1'b0;
                shreg_q <= {shreg_q[13:0], 1'b0};
                mosi_q  <= shreg_q[14];
              end
            end
          end
          GAP: begin
            if (div_end_s) begin
              state_q <= IDLE;
              div_q   <= {DIV_W{1'b0}};
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef DAC_LDAC_EN
  logic ldac_n_q;

  // One-cycle latch strobe aligned with the first GAP cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ldac_n_q <= 1'b1;
    end else begin
      ldac_n_q <= ~frame_end_s;
    end
  end

  assign dac_ldac_n = ldac_n_q;
`endif

  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_mosi   = mosi_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_filter_dac_serializer.sv
// Bench for filter_dac_serializer: timeline model of the SPI waveform plus directed frame checks.
module tb_filter_dac_serializer;
  localparam int D     = 2;
  localparam int G     = 2;
  localparam int DEPTH = 8;
  localparam int FLEN  = 33 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_out = 1'b0;
  logic [9:0] y_n = 10'h000;
  logic       dac_sclk, dac_cs_n, dac_mosi, overflow, busy;
  logic [3:0] fifo_level;
`ifdef DAC_LDAC_EN
  logic       dac_ldac_n;
`endif

  filter_dac_serializer dut (
    .clk(clk), .reset(reset), .y_n(y_n), .valid_out(valid_out),
    .dac_sclk(dac_sclk), .dac_cs_n(dac_cs_n), .dac_mosi(dac_mosi),
    .fifo_level(fifo_level), .overflow(overflow),
`ifdef DAC_LDAC_EN
    .dac_ldac_n(dac_ldac_n),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [15:0] frame_of(input logic [9:0] v);
    return {4'b0011, v ^ 10'h200, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Model: a queue of buffered samples and the start cycle of the frame in flight
  logic [9:0]  mq[$];
  logic [15:0] fm = 16'h0000;
  int          cyc = 0, fs = 0, ready = 0;
  bit          active = 1'b0, ovf_m = 1'b0, started = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
      active = 1'b0; ovf_m = 1'b0; ready = 0; started = 1'b1;
    end else if (started) begin
      if (cyc >= ready && mq.size() > 0) begin
        fm = frame_of(mq.pop_front());
        fs = cyc; active = 1'b1; ready = cyc + FLEN + G;
      end
      if (valid_out) begin
        if (mq.size() < DEPTH) mq.push_back(y_n);
        else ovf_m = 1'b1;
      end
    end
  end

  int   o, fc;
  logic e_cs, e_sclk, e_mosi, e_busy, e_ldac, a_ldac;
  logic [3:0] e_lvl;

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      o = cyc - fs;
      if (active && o < FLEN) begin
        e_cs   = 1'b0;
        e_sclk = (o >= 2*D) ? (((o - 2*D) / D) % 2 == 0) : 1'b0;
        fc     = (o >= 3*D) ? ((o - 3*D) / (2*D) + 1) : 0;
        e_mosi = fm[15 - fc];
      end else begin
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
      end
      e_busy = (active && o < FLEN + G) || (mq.size() > 0);
      e_lvl  = 4'(mq.size());
      e_ldac = !(active && o == FLEN);
      a_ldac = e_ldac;
`ifdef DAC_LDAC_EN
      a_ldac = dac_ldac_n;
`endif
      checks++;
      if ({dac_cs_n, dac_sclk, dac_mosi, fifo_level, overflow, busy, a_ldac} !==
          {e_cs, e_sclk, e_mosi, e_lvl, ovf_m, e_busy, e_ldac}) begin
        failures++;
        $display("FAIL cycle cyc=%0d got cs_n=%b sclk=%b mosi=%b lvl=%0d ovf=%b busy=%b ldac=%b want %b %b %b %0d %b %b %b",
                 cyc, dac_cs_n, dac_sclk, dac_mosi, fifo_level, overflow, busy, a_ldac,
                 e_cs, e_sclk, e_mosi, e_lvl, ovf_m, e_busy, e_ldac);
      end
    end
  end

  // Independent SPI receiver: frames, cs_n low/high lengths, fifo peak, ldac pulses
  logic [15:0] cap_q[$];
  int          low_q[$], gap_q[$], bits_q[$];
  logic [15:0] cur_frame = 16'h0000;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          cur_bits = 0, low_cnt = 0, gap_cnt = 0, falls = 0, peak = 0;
  int          ldac_lows = 0, ldac_ok = 0;
  bit          seen_rise = 1'b0;

  initial forever begin
    @(negedge clk);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
`ifdef DAC_LDAC_EN
    if (!dac_ldac_n) begin
      ldac_lows++;
      if (!prev_cs && dac_cs_n) ldac_ok++;
    end
`endif
    if (prev_cs && !dac_cs_n) begin
      cur_bits = 0; cur_frame = 16'h0000; low_cnt = 0; falls++;
      if (seen_rise) gap_q.push_back(gap_cnt);
    end
    if (!dac_cs_n) begin
      low_cnt++;
      if (!prev_sclk && dac_sclk) begin
        cur_frame = {cur_frame[14:0], dac_mosi};
        cur_bits++;
      end
    end else begin
      gap_cnt++;
    end
    if (!prev_cs && dac_cs_n) begin
      gap_cnt = 1;
      if (!reset) begin
        cap_q.push_back(cur_frame); low_q.push_back(low_cnt); bits_q.push_back(cur_bits);
        seen_rise = 1'b1;
      end else begin
        seen_rise = 1'b0;
      end
    end
    prev_cs = dac_cs_n; prev_sclk = dac_sclk;
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    chk("frames_arrived", 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || !dac_cs_n) && k < 2000) begin
      @(negedge clk); k++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic chk_frame(input string name, input int idx, input logic [15:0] exp);
    if (idx < cap_q.size()) begin
      chk(name, 32'(cap_q[idx]), 32'(exp));
      chk({name, "_bits"}, 32'(bits_q[idx]), 32'd16);
      chk({name, "_low"}, 32'(low_q[idx]), 32'(FLEN));
    end else begin
      chk(name, 32'hFFFF_FFFF, 32'(exp));
    end
  endtask

  task automatic strobe(input logic [9:0] v);
    @(negedge clk);
    y_n = v; valid_out = 1'b1;
  endtask

  task automatic strobe_end();
    @(negedge clk);
    valid_out = 1'b0;
  endtask

  logic [9:0] burst_v[10];
  int nfr, k;

  initial begin
    @(negedge clk);
    chk("reset_outputs", 32'({dac_cs_n, dac_sclk, dac_mosi, overflow, busy}), 32'b10000);
    chk("reset_level", 32'(fifo_level), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_outputs", 32'({dac_cs_n, dac_sclk, busy}), 32'b100);
    chk("idle_level", 32'(fifo_level), 32'd0);

    // Single zero sample
    strobe(10'h000); strobe_end();
    wait_frames(1, 200);
    chk_frame("frame_zero", 0, 16'h3800);

    // Max positive then most negative, back to back
    wait_idle();
    strobe(10'h1FF); strobe(10'h200); strobe_end();
    wait_frames(3, 300);
    chk_frame("frame_1ff", 1, 16'h3FFC);
    chk_frame("frame_200", 2, 16'h3000);
    chk("gap_len", 32'((gap_q.size() > 0) ? gap_q[gap_q.size()-1] : -1), 32'(G));

    // Ten-sample burst into an eight-entry FIFO
    wait_idle();
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      burst_v[i] = 10'h155 + 10'(i * 17);
      strobe(burst_v[i]);
    end
    strobe_end();
    wait_frames(12, 1200);
    chk("burst_peak", 32'(peak), 32'd8);
    chk("burst_overflow", 32'(overflow), 32'd1);
    chk_frame("burst_first", 3, 16'h3D54);
    for (int i = 1; i < 9; i++) chk_frame("burst_frame", 3 + i, frame_of(burst_v[i]));
    repeat (100) @(negedge clk);
    chk("burst_frame_count", 32'(cap_q.size()), 32'd12);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of bit 7
    wait_idle();
    strobe(10'h0AA); strobe(10'h0BB); strobe_end();
    k = 0;
    while (!(!dac_cs_n && cur_bits == 7) && k < 300) begin
      @(negedge clk); k++;
    end
    chk("reached_bit7", 32'(cur_bits), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", 32'({dac_cs_n, dac_sclk, overflow}), 32'b100);
    chk("abort_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nfr = falls;
    repeat (200) @(negedge clk);
    chk("no_frame_after_abort", 32'(falls), 32'(nfr));
    chk("abort_frame_count", 32'(cap_q.size()), 32'd12);

`ifdef DAC_LDAC_EN
    ldac_lows = 0; ldac_ok = 0;
    strobe(10'h3C3); strobe_end();
    wait_frames(13, 200);
    repeat (5) @(negedge clk);
    chk("ldac_low_cycles", 32'(ldac_lows), 32'd1);
    chk("ldac_aligned", 32'(ldac_ok), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
